// File: rtl/sort_result_dumper_pkg.sv
// Shared definitions for the post-sort result dumper.
// DRAMCON request codes, default key width, FSM state types and a saturating increment.
// Imported by the dumper top and its word FIFO.
package sort_result_dumper_pkg;

   localparam logic [1:0] DRAM_REQ_READ  = 2'd1;
   localparam logic [1:0] DRAM_REQ_WRITE = 2'd2;
   localparam int         KEYW_DEF       = 32;
   localparam int         PHASE_W        = 5;

   typedef enum logic [1:0] {RD_IDLE, RD_JUDGE, RD_REQ, RD_WAIT} rd_state_t;
   typedef enum logic [2:0] {OUT_KEYS, OUT_PCNT, OUT_SUM, OUT_ERR, OUT_FIN} out_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sort_result_dumper_wfifo.sv
// Purpose: first-word-fall-through FIFO holding whole DRAM read words for the dumper.
// Latency: a written word is visible on o_rdat the cycle after the write.
// Backpressure: none on the write side; the producer reserves slots before requesting.
module dump_wfifo
   import sort_result_dumper_pkg::*;
#(
   parameter int W   = 512,
   parameter int LOG = 7
) (
   input  logic         CLK,
   input  logic         RST_X,
   input  logic         i_we,
   input  logic [W-1:0] i_wdat,
   input  logic         i_re,
   output logic [W-1:0] o_rdat,
   output logic [LOG:0] o_cnt,
   output logic         o_emp,
   output logic         o_full
);

   localparam int DEPTH = 1 << LOG;

   logic [W-1:0]   r_mem [DEPTH];
   logic [LOG-1:0] r_wptr;
   logic [LOG-1:0] r_rptr;
   logic [LOG:0]   r_cnt;
   logic           w_pop;

   assign w_pop  = i_re && !o_emp;
   assign o_emp  = (r_cnt == '0);
   assign o_full = (r_cnt == (LOG+1)'(DEPTH));
   assign o_cnt  = r_cnt;
   assign o_rdat = r_mem[r_rptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge CLK) begin
      if (i_we) r_mem[r_wptr] <= i_wdat;
   end

   // Pointers and occupancy count.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_we)  r_wptr <= r_wptr + LOG'(1);
         if (w_pop) r_rptr <= r_rptr + LOG'(1);
         r_cnt <= r_cnt + (LOG+1)'(i_we) - (LOG+1)'(w_pop);
      end
   end

   // The reader only requests when enough slots are free, so a write into a full FIFO is a bug.
   a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_X) !(i_we && o_full));

endmodule

// File: rtl/sort_result_dumper.sv
// Purpose: read the sorted region back from DRAM, stream the first SHOWNUM keys, check order, send a trailer.
// Latency: keys appear on tx a few cycles after the read data; done follows the last transmit by one cycle.
// Backpressure: tx_rdy gates each transmit (never back-to-back); DRAM reads only issue with VBLOCKS free slots.
module sort_result_dumper
   import sort_result_dumper_pkg::*;
#(
   parameter int          DRAMW     = 512,
   parameter int          KEYW      = KEYW_DEF,
   parameter int          SORT_ELM  = 65536,
   parameter int          VBLOCKS   = 64,
   parameter int          ADDR_STEP = 512,
   parameter logic [31:0] BASE0     = 32'd0,
   parameter logic [31:0] BASE1     = 32'(SORT_ELM >> 1),
   parameter int          FIFO_LOG  = 7,
   parameter int          SHOWNUM   = 1024,
   parameter int          ASCEND    = 1,
   parameter int          TRAILER   = 1
) (
   input  logic             CLK,
   input  logic             RST_X,
   input  logic             start,
   input  logic             region_sel,
   input  logic [31:0]      pcnt,
   input  logic             d_busy,
   output logic [1:0]       d_req,
   output logic [31:0]      d_initadr,
   output logic [31:0]      d_blocks,
   input  logic [DRAMW-1:0] d_dout,
   input  logic             d_douten,
   input  logic             tx_rdy,
   output logic             tx_we,
   output logic [KEYW-1:0]  tx_data,
   output logic             done,
   output logic             sorted_ok,
   output logic [31:0]      err_cnt
);

   localparam int L      = DRAMW / KEYW;
   localparam int LANE_W = (L > 1) ? $clog2(L) : 1;
   localparam int NREQ   = SORT_ELM * KEYW / (DRAMW * VBLOCKS);
   localparam int RCNT_W = $clog2(NREQ + 1);
   localparam int DEPTH  = 1 << FIFO_LOG;

   // ---------------- word FIFO ----------------
   logic [DRAMW-1:0]  w_fifo_dout;
   logic [FIFO_LOG:0] w_fifo_cnt;
   logic              w_fifo_emp;
   logic              w_fifo_full;
   logic              w_deq;

   dump_wfifo #(.W(DRAMW), .LOG(FIFO_LOG)) u_wfifo (
      .CLK    (CLK),
      .RST_X  (RST_X),
      .i_we   (d_douten),
      .i_wdat (d_dout),
      .i_re   (w_deq),
      .o_rdat (w_fifo_dout),
      .o_cnt  (w_fifo_cnt),
      .o_emp  (w_fifo_emp),
      .o_full (w_fifo_full)
   );

   // ---------------- read request FSM ----------------
   rd_state_t         r_rd_st;
   logic [31:0]       r_addr;
   logic [RCNT_W-1:0] r_reqs;
   logic [31:0]       r_pcnt;
   logic              r_busy_d;
   logic [1:0]        r_d_req;
   logic [31:0]       r_d_initadr;
   logic [31:0]       r_d_blocks;
   logic              w_room;

   // A whole burst must fit in the FIFO before it is requested.
   assign w_room = !w_fifo_full && ((32'(w_fifo_cnt) + 32'(VBLOCKS)) <= 32'(DEPTH));

   // Issue NREQ one-cycle read requests, waiting for DRAMCON to finish each burst.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_rd_st     <= RD_IDLE;
         r_addr      <= '0;
         r_reqs      <= '0;
         r_pcnt      <= '0;
         r_busy_d    <= 1'b0;
         r_d_req     <= '0;
         r_d_initadr <= '0;
         r_d_blocks  <= '0;
      end else begin
         r_busy_d <= d_busy;
         r_d_req  <= '0;
         case (r_rd_st)
            RD_IDLE: if (start) begin
               r_addr  <= region_sel ? BASE1 : BASE0;
               r_pcnt  <= pcnt;
               r_rd_st <= RD_JUDGE;
            end
            RD_JUDGE: if (!d_busy && w_room && (r_reqs < RCNT_W'(NREQ))) r_rd_st <= RD_REQ;
            RD_REQ: if (!d_busy) begin
               r_d_req     <= DRAM_REQ_READ;
               r_d_initadr <= r_addr;
               r_d_blocks  <= 32'(VBLOCKS);
               r_addr      <= r_addr + 32'(ADDR_STEP);
               r_reqs      <= r_reqs + RCNT_W'(1);
               r_rd_st     <= RD_WAIT;
            end
            default: if (r_busy_d && !d_busy) r_rd_st <= RD_JUDGE;
         endcase
      end
   end

   assign d_req     = r_d_req;
   assign d_initadr = r_d_initadr;
   assign d_blocks  = r_d_blocks;

   // ---------------- serializer, checker, trailer ----------------
   out_state_t        r_out_st;
   logic [LANE_W-1:0] r_lane;
   logic [31:0]       r_kidx;
   logic [KEYW-1:0]   r_prev;
   logic [31:0]       r_sum;
   logic [31:0]       r_err;
   logic              r_tx_we;
   logic [KEYW-1:0]   r_tx_data;
   logic              r_done;
   logic              r_sorted_ok;
   logic [KEYW-1:0]   w_key;
   logic              w_show;
   logic              w_tx_ok;
   logic              w_take;
   logic              w_last_lane;
   logic              w_viol;

   assign w_key       = w_fifo_dout[r_lane*KEYW +: KEYW];
   assign w_show      = (r_kidx < 32'(SHOWNUM));
   assign w_tx_ok     = tx_rdy && !r_tx_we;
   assign w_take      = (r_out_st == OUT_KEYS) && !w_fifo_emp && (!w_show || w_tx_ok);
   assign w_last_lane = (r_lane == LANE_W'(L - 1));
   assign w_deq       = w_take && w_last_lane;
   assign w_viol      = (r_kidx != 32'd0) &&
                        ((ASCEND != 0) ? (w_key < r_prev) : (w_key > r_prev));

   // Consume one key per cycle, transmit the shown ones, then send the trailer words.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_out_st    <= OUT_KEYS;
         r_lane      <= '0;
         r_kidx      <= '0;
         r_prev      <= '0;
         r_sum       <= '0;
         r_err       <= '0;
         r_tx_we     <= 1'b0;
         r_tx_data   <= '0;
         r_done      <= 1'b0;
         r_sorted_ok <= 1'b0;
      end else begin
         r_tx_we <= 1'b0;
         case (r_out_st)
            OUT_KEYS: if (w_take) begin
               if (w_show) begin
                  r_tx_we   <= 1'b1;
                  r_tx_data <= w_key;
               end
               r_sum  <= r_sum + 32'(w_key);
               if (w_viol) r_err <= sat_inc(r_err);
               r_prev <= w_key;
               r_kidx <= r_kidx + 32'd1;
               r_lane <= w_last_lane ? '0 : r_lane + LANE_W'(1);
               if (r_kidx == 32'(SORT_ELM - 1)) begin
                  if (TRAILER != 0) begin
                     r_out_st <= OUT_PCNT;
                  end else begin
                     r_out_st    <= OUT_FIN;
                     r_done      <= 1'b1;
                     r_sorted_ok <= (r_err == 32'd0) && !w_viol;
                  end
               end
            end
            OUT_PCNT: if (w_tx_ok) begin
               r_tx_we   <= 1'b1;
               r_tx_data <= KEYW'(r_pcnt);
               r_out_st  <= OUT_SUM;
            end
            OUT_SUM: if (w_tx_ok) begin
               r_tx_we   <= 1'b1;
               r_tx_data <= KEYW'(r_sum);
               r_out_st  <= OUT_ERR;
            end
            OUT_ERR: if (w_tx_ok) begin
               r_tx_we   <= 1'b1;
               r_tx_data <= KEYW'(r_err);
               r_out_st  <= OUT_FIN;
            end
            default: begin
               r_done      <= 1'b1;
               r_sorted_ok <= (r_err == 32'd0);
            end
         endcase
      end
   end

   assign tx_we     = r_tx_we;
   assign tx_data   = r_tx_data;
   assign done      = r_done;
   assign sorted_ok = r_sorted_ok;
   assign err_cnt   = r_err;

endmodule

// File: tb/tb_sort_result_dumper.sv
// Bench for sort_result_dumper: small 128-bit DRAM config, behavioural DRAMCON and LCDCON models.
// Two instances share clock/reset: SHOWNUM=64 and SHOWNUM=8.
// Expected tx streams come from a key-array reference model (shown keys, pcnt, sum, inversion count).
module tb_sort_result_dumper;
   import sort_result_dumper_pkg::*;

   localparam int DRAMW     = 128;
   localparam int KEYW      = 32;
   localparam int SORT_ELM  = 64;
   localparam int VBLOCKS   = 4;
   localparam int ADDR_STEP = 512;
   localparam int BASE1     = 32;
   localparam int L         = DRAMW / KEYW;
   localparam int TMO       = 20000;

   logic              CLK        = 1'b0;
   logic              RST_X      = 1'b0;
   logic              region_sel = 1'b0;
   logic [31:0]       pcnt       = 32'd0;
   logic              tx_rdy     = 1'b0;
   logic              start     [2] = '{default: 1'b0};
   logic              d_busy    [2];
   logic [1:0]        d_req     [2];
   logic [31:0]       d_initadr [2];
   logic [31:0]       d_blocks  [2];
   logic [DRAMW-1:0]  d_dout    [2];
   logic              d_douten  [2];
   logic              tx_we     [2];
   logic [KEYW-1:0]   tx_data   [2];
   logic              done      [2];
   logic              sorted_ok [2];
   logic [31:0]       err_cnt   [2];

   always #5 CLK = ~CLK;

   sort_result_dumper #(.DRAMW(DRAMW), .KEYW(KEYW), .SORT_ELM(SORT_ELM), .VBLOCKS(VBLOCKS),
      .ADDR_STEP(ADDR_STEP), .BASE0(32'd0), .BASE1(32'(BASE1)), .FIFO_LOG(3), .SHOWNUM(64),
      .ASCEND(1), .TRAILER(1)) u_dut0 (
      .CLK(CLK), .RST_X(RST_X), .start(start[0]), .region_sel(region_sel), .pcnt(pcnt),
      .d_busy(d_busy[0]), .d_req(d_req[0]), .d_initadr(d_initadr[0]), .d_blocks(d_blocks[0]),
      .d_dout(d_dout[0]), .d_douten(d_douten[0]), .tx_rdy(tx_rdy), .tx_we(tx_we[0]),
      .tx_data(tx_data[0]), .done(done[0]), .sorted_ok(sorted_ok[0]), .err_cnt(err_cnt[0]));

   sort_result_dumper #(.DRAMW(DRAMW), .KEYW(KEYW), .SORT_ELM(SORT_ELM), .VBLOCKS(VBLOCKS),
      .ADDR_STEP(ADDR_STEP), .BASE0(32'd0), .BASE1(32'(BASE1)), .FIFO_LOG(3), .SHOWNUM(8),
      .ASCEND(1), .TRAILER(1)) u_dut1 (
      .CLK(CLK), .RST_X(RST_X), .start(start[1]), .region_sel(region_sel), .pcnt(pcnt),
      .d_busy(d_busy[1]), .d_req(d_req[1]), .d_initadr(d_initadr[1]), .d_blocks(d_blocks[1]),
      .d_dout(d_dout[1]), .d_douten(d_douten[1]), .tx_rdy(tx_rdy), .tx_we(tx_we[1]),
      .tx_data(tx_data[1]), .done(done[1]), .sorted_ok(sorted_ok[1]), .err_cnt(err_cnt[1]));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] keys [SORT_ELM];
   logic [31:0] txq0[$];
   logic [31:0] txq1[$];
   logic [31:0] addrq[$];
   logic [31:0] expq[$];
   int unsigned exp_err;
   int          rdy_pct  = 100;
   int          maxlat   = 0;
   logic [31:0] cur_base = 32'd0;
   int          ph [2], lat [2], nw [2], wbase [2], run [2], maxrun [2], reqcnt [2], b2b [2];
   logic        prev_we [2];

   function automatic logic [DRAMW-1:0] mkword(input int w);
      logic [DRAMW-1:0] r;
      r = '0;
      for (int l = 0; l < L; l++) r[l*KEYW +: KEYW] = keys[(w*L + l) % SORT_ELM];
      return r;
   endfunction

   // DRAMCON model: busy on request, random latency, then VBLOCKS back-to-back words.
   always @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         for (int ch = 0; ch < 2; ch++) begin
            ph[ch] = 0; run[ch] = 0; maxrun[ch] = 0; reqcnt[ch] = 0;
            d_busy[ch] <= 1'b0; d_douten[ch] <= 1'b0; d_dout[ch] <= '0;
         end
         addrq.delete();
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (d_req[ch] != 2'd0) begin
               run[ch]++;
               if (run[ch] > maxrun[ch]) maxrun[ch] = run[ch];
            end else run[ch] = 0;
            case (ph[ch])
               0: if (d_req[ch] == DRAM_REQ_READ) begin
                  reqcnt[ch]++;
                  if (ch == 0) addrq.push_back(d_initadr[0]);
                  wbase[ch] = int'((d_initadr[ch] - cur_base) / ADDR_STEP) * VBLOCKS;
                  lat[ch]   = int'($urandom_range(maxlat, 0));
                  ph[ch]    = 1;
                  d_busy[ch] <= 1'b1;
               end
               1: if (lat[ch] == 0) begin ph[ch] = 2; nw[ch] = 0; end
                  else lat[ch]--;
               default: if (nw[ch] == VBLOCKS) begin
                  d_douten[ch] <= 1'b0; d_busy[ch] <= 1'b0; ph[ch] = 0;
               end else begin
                  d_dout[ch] <= mkword(wbase[ch] + nw[ch]); d_douten[ch] <= 1'b1; nw[ch]++;
               end
            endcase
         end
      end
   end

   // LCDCON model: ready with the configured duty, re-drawn every cycle.
   always @(posedge CLK) begin
      #1;
      tx_rdy = ($urandom_range(99, 0) < rdy_pct);
   end

   // Transmit monitor, sampled mid-cycle.
   always @(negedge CLK) begin
      if (!RST_X) begin
         txq0.delete(); txq1.delete();
         for (int ch = 0; ch < 2; ch++) begin b2b[ch] = 0; prev_we[ch] = 1'b0; end
      end else begin
         if (tx_we[0]) txq0.push_back(tx_data[0]);
         if (tx_we[1]) txq1.push_back(tx_data[1]);
         for (int ch = 0; ch < 2; ch++) begin
            if (tx_we[ch] && prev_we[ch]) b2b[ch]++;
            prev_we[ch] = tx_we[ch];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: shown keys, then pcnt, sum mod 2^32, count of descents.
   task automatic make_exp(input int shown, input logic [31:0] pc);
      logic [31:0] sum;
      int unsigned err;
      sum = 32'd0; err = 0;
      expq.delete();
      for (int i = 0; i < SORT_ELM; i++) begin
         sum += keys[i];
         if (i > 0 && keys[i] < keys[i-1]) err++;
         if (i < shown) expq.push_back(keys[i]);
      end
      expq.push_back(pc); expq.push_back(sum); expq.push_back(err);
      exp_err = err;
   endtask

   task automatic start_case(input int ch, input bit rsel, input logic [31:0] pc);
      @(posedge CLK); #1;
      RST_X = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset done", done[ch], 0);
      chk("reset tx_we", tx_we[ch], 0);
      chk("reset err_cnt", err_cnt[ch], 0);
      chk("reset d_req", d_req[ch], 0);
      region_sel = rsel; cur_base = rsel ? 32'(BASE1) : 32'd0; pcnt = pc;
      RST_X = 1'b1;
      @(posedge CLK); #1 start[ch] = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      pcnt = ~pc; start[ch] = 1'b0;   // must be ignored after the launch
   endtask

   task automatic finish_case(input string tag, input int ch, input int shown, input logic [31:0] pc);
      logic [31:0] got[$];
      logic [31:0] obs;
      for (int c = 0; c < TMO && !done[ch]; c++) @(negedge CLK);
      chk({tag, " done"}, done[ch], 1);
      repeat (5) @(negedge CLK);
      got = (ch == 0) ? txq0 : txq1;
      make_exp(shown, pc);
      chk({tag, " tx count"}, got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 'x;
         chk($sformatf("%s tx[%0d]", tag, i), obs, expq[i]);
      end
      chk({tag, " err_cnt"}, err_cnt[ch], exp_err);
      chk({tag, " sorted_ok"}, sorted_ok[ch], (exp_err == 0) ? 32'd1 : 32'd0);
      chk({tag, " requests"}, reqcnt[ch], 4);
      chk({tag, " req width"}, maxrun[ch], 1);
      chk({tag, " tx back-to-back"}, b2b[ch], 0);
   endtask

   initial begin
      logic [31:0] t;
      logic [31:0] pc;
      // T1: ascending 0..63, always ready, zero read latency
      for (int i = 0; i < SORT_ELM; i++) keys[i] = i;
      start_case(0, 1'b0, 32'd1000);
      finish_case("T1", 0, 64, 32'd1000);
      chk("T1 pcnt word", (txq0.size() == 67) ? txq0[64] : 'x, 32'd1000);
      chk("T1 checksum", (txq0.size() == 67) ? txq0[65] : 'x, 32'd2016);
      chk("T1 err word", (txq0.size() == 67) ? txq0[66] : 'x, 32'd0);
      chk("T1 sorted_ok", sorted_ok[0], 1);
      chk("T1 d_blocks", d_blocks[0], VBLOCKS);
      chk("T1 addr count", addrq.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("T1 addr[%0d]", k), (k < addrq.size()) ? addrq[k] : 'x, 32'(k*ADDR_STEP));

      // T2+T3: keys 10/11 swapped, upper region
      t = keys[10]; keys[10] = keys[11]; keys[11] = t;
      start_case(0, 1'b1, 32'd1000);
      finish_case("T2", 0, 64, 32'd1000);
      chk("T2 err_cnt", err_cnt[0], 1);
      chk("T2 sorted_ok", sorted_ok[0], 0);
      chk("T2 checksum", (txq0.size() == 67) ? txq0[65] : 'x, 32'd2016);
      chk("T3 addr count", addrq.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("T3 addr[%0d]", k), (k < addrq.size()) ? addrq[k] : 'x, 32'(BASE1 + k*ADDR_STEP));

      // T4: random ascending keys with duplicates, 30% ready, latency 0..20
      rdy_pct = 30; maxlat = 20;
      keys[0] = $urandom_range(100000, 0);
      for (int i = 1; i < SORT_ELM; i++) keys[i] = keys[i-1] + $urandom_range(3, 0);
      pc = $urandom;
      start_case(0, 1'($urandom_range(1, 0)), pc);
      finish_case("T4", 0, 64, pc);

      // T4b: fully random keys exercise violation counting and checksum wrap
      rdy_pct = 50; maxlat = 5;
      for (int i = 0; i < SORT_ELM; i++) keys[i] = $urandom;
      pc = $urandom;
      start_case(0, 1'b0, pc);
      finish_case("T4b", 0, 64, pc);

      // T5: SHOWNUM=8 instance, checksum still covers every key
      rdy_pct = 70; maxlat = 3;
      for (int i = 0; i < SORT_ELM; i++) keys[i] = 32'(i * 3 + 7);
      start_case(1, 1'b0, 32'd4242);
      finish_case("T5", 1, 8, 32'd4242);

      // T6: reset mid-transfer, then full rerun
      rdy_pct = 60; maxlat = 4;
      for (int i = 0; i < SORT_ELM; i++) keys[i] = 32'(i * 5);
      start_case(0, 1'b0, 32'd777);
      for (int c = 0; c < TMO && txq0.size() <= 20; c++) @(negedge CLK);
      chk("T6 reached key 20", (txq0.size() > 20) ? 32'd1 : 32'd0, 1);
      @(posedge CLK); #1 RST_X = 1'b0;
      #1;
      chk("T6 abort tx_we", tx_we[0], 0);
      chk("T6 abort tx_data", tx_data[0], 0);
      chk("T6 abort done", done[0], 0);
      chk("T6 abort d_req", d_req[0], 0);
      chk("T6 abort d_initadr", d_initadr[0], 0);
      start_case(0, 1'b0, 32'd777);
      finish_case("T6", 0, 64, 32'd777);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
